qoi_encoder_core: RTL and testbench

QOI_ENCODER_CORE -- requirements
Module: qoi_encoder_core

---
 rtl/qoi_types.sv | 34 +++
 rtl/qoi_index_table.sv | 35 +++
 rtl/qoi_encoder_core.sv | 215 +++++++++++++++++++++
 tb/tb_qoi_encoder_core.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qoi_types.sv
`default_nettype none
// qoi_types -- shared types, opcodes and FSM states for the QOI encoder core.
// Rev 1.0
package qoi_types;

    localparam int ADDR_W  = 8;
    localparam int MAX_RUN = 62;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [7:0]        byte_t;

    typedef struct packed {
        byte_t r;
        byte_t g;
        byte_t b;
        byte_t a;
    } pixel_t;

    localparam byte_t OP_INDEX = 8'h00;
    localparam byte_t OP_RUN   = 8'hC0;
    localparam byte_t OP_RGB   = 8'hFE;
    localparam byte_t OP_RGBA  = 8'hFF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        ENCODE = 3'd2,
        EMIT   = 3'd3,
        FLUSH  = 3'd4,
        DONE   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/qoi_index_table.sv
`default_nettype none
// qoi_index_table -- 64-entry recently-seen pixel table with QOI hash lookup.
// Rev 1.0
module qoi_index_table
    import qoi_types::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        wr_en,
    input  logic [31:0] pix,
    output logic [5:0]  hash,
    output logic        hit
);

    pixel_t p;
    pixel_t tbl [64];

    assign p = pixel_t'(pix);
    // Truncating each channel to 6 bits first keeps the whole sum mod 64.
    assign hash = 6'(p.r) * 6'd3 + 6'(p.g) * 6'd5 + 6'(p.b) * 6'd7 + 6'(p.a) * 6'd11;
    assign hit  = (tbl[hash] == p);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) tbl[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < 64; i++) tbl[i] <= '0;
        end else if (wr_en) begin
            tbl[hash] <= p;
        end
    end

endmodule
`default_nettype wire

// File: rtl/qoi_encoder_core.sv
`default_nettype none
// qoi_encoder_core -- QOI chunk encoder on a shared port-B memory; define QOI_INDEX_EN to add index chunks.
// Rev 1.0
module qoi_encoder_core
    import qoi_types::*;
#(
    parameter int CHANNELS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] pixel_count,
    output logic       sel,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    output logic [7:0] mem_wdata,
    output logic       mem_cs,
    output logic       mem_we,
    output logic       busy,
    output logic       done,
    output logic [7:0] out_len,
    output logic       err
);

    localparam logic [2:0] NCH      = 3'(CHANNELS);
    localparam logic [5:0] RUN_WRAP = 6'(MAX_RUN - 1);

    state_t     state, state_nx;
    logic [2:0] fcnt;
    byte_t      pix_b [4];
    pixel_t     prev, cur;
    logic [5:0] run;
    addr_t      src_addr, pix_left;
    byte_t      ebuf [8];
    logic [2:0] elen, eidx;
    byte_t      enc_buf [8];
    logic [2:0] enc_len;
    byte_t      chunk [5];
    logic [2:0] chunk_len;
    logic       match, idx_hit;
    logic [5:0] idx_hash;

    always_comb begin
        cur.r = pix_b[0];
        cur.g = pix_b[1];
        cur.b = pix_b[2];
        cur.a = (CHANNELS == 4) ? pix_b[3] : 8'hFF;
    end
    assign match = (cur == prev);

`ifdef QOI_INDEX_EN
    qoi_index_table u_index (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state == IDLE && start),
        .wr_en (state == ENCODE),
        .pix   (cur),
        .hash  (idx_hash),
        .hit   (idx_hit)
    );
`else
    assign idx_hit  = 1'b0;
    assign idx_hash = '0;
`endif

    always_comb begin
        for (int i = 0; i < 5; i++) chunk[i] = '0;
        chunk_len = '0;
        if (idx_hit) begin
            chunk[0]  = OP_INDEX | {2'b00, idx_hash};
            chunk_len = 3'd1;
        end else if (cur.a == prev.a) begin
            chunk[0] = OP_RGB;
            chunk[1] = cur.r;
            chunk[2] = cur.g;
            chunk[3] = cur.b;
            chunk_len = 3'd4;
        end else begin
            chunk[0] = OP_RGBA;
            chunk[1] = cur.r;
            chunk[2] = cur.g;
            chunk[3] = cur.b;
            chunk[4] = cur.a;
            chunk_len = 3'd5;
        end
    end

    // A pending run is closed ahead of the chunk for the first differing pixel.
    always_comb begin
        for (int i = 0; i < 8; i++) enc_buf[i] = '0;
        enc_len = '0;
        if (match) begin
            if (run == RUN_WRAP) begin
                enc_buf[0] = OP_RUN | {2'b00, RUN_WRAP};
                enc_len    = 3'd1;
            end
        end else if (run != 6'd0) begin
            enc_buf[0] = OP_RUN | {2'b00, run - 6'd1};
            for (int i = 0; i < 5; i++) enc_buf[i+1] = chunk[i];
            enc_len = chunk_len + 3'd1;
        end else begin
            for (int i = 0; i < 5; i++) enc_buf[i] = chunk[i];
            enc_len = chunk_len;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = src_addr;
        mem_wdata = ebuf[eidx];
        case (state)
            IDLE: begin
                if (start) state_nx = (pixel_count != 8'd0) ? FETCH : DONE;
            end
            FETCH: begin
                busy   = 1'b1;
                mem_cs = (fcnt < NCH);
                if (fcnt == NCH) state_nx = ENCODE;
            end
            ENCODE: begin
                busy = 1'b1;
                if (enc_len != 3'd0)       state_nx = EMIT;
                else if (pix_left == 8'd1) state_nx = FLUSH;
                else                       state_nx = FETCH;
            end
            EMIT: begin
                busy     = 1'b1;
                mem_addr = out_len;
                mem_cs   = (out_len != 8'hFF);
                mem_we   = (out_len != 8'hFF);
                if (out_len == 8'hFF)          state_nx = DONE;
                else if (eidx == elen - 3'd1)  state_nx = (pix_left != 8'd0) ? FETCH : FLUSH;
            end
            FLUSH: begin
                busy     = 1'b1;
                state_nx = (run != 6'd0) ? EMIT : DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign sel = busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt     <= '0;
            for (int i = 0; i < 4; i++) pix_b[i] <= '0;
            prev     <= '0;
            run      <= '0;
            src_addr <= '0;
            pix_left <= '0;
            for (int i = 0; i < 8; i++) ebuf[i] <= '0;
            elen     <= '0;
            eidx     <= '0;
            out_len  <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    out_len  <= '0;
                    err      <= 1'b0;
                    run      <= '0;
                    prev     <= '{r: 8'd0, g: 8'd0, b: 8'd0, a: 8'hFF};
                    pix_left <= pixel_count;
                    src_addr <= '0;
                    fcnt     <= '0;
                end
                FETCH: begin
                    fcnt <= fcnt + 3'd1;
                    if (fcnt < NCH)   src_addr <= src_addr + 8'd1;
                    if (fcnt != 3'd0) pix_b[2'(fcnt - 3'd1)] <= mem_rdata;
                end
                ENCODE: begin
                    fcnt     <= '0;
                    pix_left <= pix_left - 8'd1;
                    prev     <= cur;
                    run      <= (match && run != RUN_WRAP) ? run + 6'd1 : 6'd0;
                    for (int i = 0; i < 8; i++) ebuf[i] <= enc_buf[i];
                    elen     <= enc_len;
                    eidx     <= '0;
                end
                EMIT: begin
                    if (out_len == 8'hFF) begin
                        err <= 1'b1;
                    end else begin
                        out_len <= out_len + 8'd1;
                        eidx    <= eidx + 3'd1;
                    end
                end
                FLUSH: if (run != 6'd0) begin
                    ebuf[0] <= OP_RUN | {2'b00, run - 6'd1};
                    elen    <= 3'd1;
                    eidx    <= '0;
                    run     <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qoi_encoder_core.sv
`default_nettype none
// tb_qoi_encoder_core -- randomized self-checking bench with a queue-based QOI stream model.
// Rev 1.0
module tb_qoi_encoder_core;

    localparam int C     = 4;
    localparam int LIMIT = 5000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] pixel_count = '0;
    logic       sel, mem_cs, mem_we, busy, done, err;
    logic [7:0] mem_addr, mem_wdata, out_len;
    logic [7:0] mem_rdata = '0;

    logic [7:0] in_buf  [256];
    logic [7:0] out_buf [256];
    logic [7:0] exp_q [$];

    int checks = 0;
    int errors = 0;
    int wr_idx = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    qoi_encoder_core #(.CHANNELS(C)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pixel_count(pixel_count),
        .sel        (sel),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_wdata  (mem_wdata),
        .mem_cs     (mem_cs),
        .mem_we     (mem_we),
        .busy       (busy),
        .done       (done),
        .out_len    (out_len),
        .err        (err)
    );

    always @(posedge clk) begin
        if (mem_cs && !mem_we) mem_rdata <= in_buf[mem_addr];
        if (mem_cs && mem_we)  out_buf[mem_addr] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] pixel_at(input int i);
        logic [31:0] p;
        p = 32'h000000FF;
        for (int k = 0; k < C; k++) p[31-8*k -: 8] = in_buf[(i*C+k) % 256];
        return p;
    endfunction

    function automatic logic [5:0] hash6(input logic [31:0] p);
        int s;
        s = 3*int'(p[31:24]) + 5*int'(p[23:16]) + 7*int'(p[15:8]) + 11*int'(p[7:0]);
        return 6'(s % 64);
    endfunction

    task automatic set_pixel(input int i, input logic [31:0] p);
        for (int k = 0; k < C; k++) in_buf[(i*C+k) % 256] = p[31-8*k -: 8];
    endtask

    // Full chunk stream the frame should produce, before any buffer-size cap.
    task automatic build_model(input int n);
        logic [31:0] prv, p;
        int          run;
        logic        hit_m;
`ifdef QOI_INDEX_EN
        logic [31:0] tbl [64];
        logic [5:0]  h;
        for (int k = 0; k < 64; k++) tbl[k] = '0;
`endif
        exp_q.delete();
        prv = 32'h000000FF;
        run = 0;
        for (int i = 0; i < n; i++) begin
            p = pixel_at(i);
            hit_m = 1'b0;
            if (p == prv) begin
                run++;
                if (run == 62) begin
                    exp_q.push_back(8'hFD);
                    run = 0;
                end
            end else begin
                if (run > 0) exp_q.push_back(8'hC0 + 8'(run - 1));
                run = 0;
`ifdef QOI_INDEX_EN
                h = hash6(p);
                if (tbl[h] == p) begin
                    hit_m = 1'b1;
                    exp_q.push_back({2'b00, h});
                end
`endif
                if (!hit_m) begin
                    if (p[7:0] == prv[7:0]) begin
                        exp_q.push_back(8'hFE);
                    end else begin
                        exp_q.push_back(8'hFF);
                    end
                    exp_q.push_back(p[31:24]);
                    exp_q.push_back(p[23:16]);
                    exp_q.push_back(p[15:8]);
                    if (p[7:0] != prv[7:0]) exp_q.push_back(p[7:0]);
                end
            end
`ifdef QOI_INDEX_EN
            tbl[hash6(p)] = p;
`endif
            prv = p;
        end
        if (run > 0) exp_q.push_back(8'hC0 + 8'(run - 1));
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("sel_eq_busy", sel, busy);
            if (mem_cs && !sel) check("cs_without_sel", mem_cs, 1'b0);
            if (mem_cs && mem_we) begin
                check("wr_in_range", (wr_idx < exp_q.size()) ? 1 : 0, 1);
                if (wr_idx < exp_q.size()) begin
                    check("wr_addr", mem_addr, wr_idx[7:0]);
                    check("wr_data", mem_wdata, exp_q[wr_idx]);
                end
                wr_idx++;
            end
            if (done) done_cnt++;
        end
    end

    task automatic run_frame(input int n, input bit restart);
        int cyc;
        int exp_len;
        build_model(n);
        wr_idx   = 0;
        done_cnt = 0;
        @(posedge clk); #1;
        pixel_count = 8'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (restart) begin
            repeat (8) @(posedge clk);
            #1;
            pixel_count = 8'd1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        cyc = 0;
        while (done_cnt == 0 && cyc < LIMIT) begin
            @(posedge clk);
            cyc++;
        end
        check("done_timeout", (done_cnt != 0) ? 1 : 0, 1);
        repeat (3) @(posedge clk);
        #1;
        exp_len = (exp_q.size() > 255) ? 255 : exp_q.size();
        check("done_once", done_cnt, 1);
        check("out_len", out_len, exp_len);
        check("err", err, (exp_q.size() > 255) ? 1 : 0);
        check("write_count", wr_idx, exp_len);
        check("busy_after_done", busy, 1'b0);
    endtask

    task automatic random_pixels(input int n);
        logic [31:0] pal [4];
        logic [31:0] cp;
        for (int k = 0; k < 4; k++) begin
            pal[k] = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      8'($urandom_range(0, 255)), (k < 2) ? 8'hFF : 8'($urandom_range(0, 255))};
        end
        cp = pal[0];
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) != 0) cp = pal[$urandom_range(0, 3)];
            if ($urandom_range(0, 5) == 0) cp[7:0] = 8'($urandom_range(0, 255));
            set_pixel(i, cp);
        end
    endtask

    initial begin
        int cyc;
        int n;
        for (int i = 0; i < 256; i++) begin
            in_buf[i]  = '0;
            out_buf[i] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_sel", sel, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_out_len", out_len, 8'd0);
        check("rst_cs", mem_cs, 1'b0);
        check("rst_we", mem_we, 1'b0);
        rst_n = 1'b1;

        set_pixel(0, 32'h0A141EFF);
        run_frame(1, 1'b0);
        check("single_model_len", exp_q.size(), 4);
        check("single_b0", out_buf[0], 8'hFE);
        check("single_b1", out_buf[1], 8'h0A);
        check("single_b2", out_buf[2], 8'h14);
        check("single_b3", out_buf[3], 8'h1E);
        check("single_len", out_len, 8'd4);

        for (int i = 0; i < 64; i++) set_pixel(i, 32'h000000FF);
        run_frame(70, 1'b0);
        check("run_b0", out_buf[0], 8'hFD);
        check("run_b1", out_buf[1], 8'hC7);
        check("run_len", out_len, 8'd2);

        set_pixel(0, 32'h01020304);
        set_pixel(1, 32'h05060708);
        set_pixel(2, 32'h01020304);
        run_frame(3, 1'b0);
        check("aba_b0", out_buf[0], 8'hFF);
        check("aba_b9", out_buf[9], 8'h08);
`ifdef QOI_INDEX_EN
        check("aba_len", out_len, 8'd11);
        check("aba_index", out_buf[10], 8'h0E);
`else
        check("aba_len", out_len, 8'd15);
        check("aba_b10", out_buf[10], 8'hFF);
        check("aba_b14", out_buf[14], 8'h04);
`endif

        for (int i = 0; i < 64; i++)
            set_pixel(i, {8'(i), 8'(i + 1), 8'(i + 2), (i % 2 == 1) ? 8'h80 : 8'hFF});
        run_frame(64, 1'b0);
        check("ovf_err", err, 1'b1);
        check("ovf_len", out_len, 8'd255);

        run_frame(0, 1'b0);
        check("zero_len", out_len, 8'd0);
        check("zero_err", err, 1'b0);

        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(10, 60);
            random_pixels(n);
            run_frame(n, (f == 3));
        end

        n = 40;
        for (int i = 0; i < n; i++)
            set_pixel(i, {8'(i * 7), 8'(i * 3), 8'(i), (i % 2 == 1) ? 8'h40 : 8'hFF});
        build_model(n);
        wr_idx   = 0;
        done_cnt = 0;
        @(posedge clk); #1;
        pixel_count = 8'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while ((wr_idx < 3 || !mem_we) && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        check("emit_reached", (wr_idx >= 3 && mem_we) ? 1 : 0, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_sel", sel, 1'b0);
        check("midrst_cs", mem_cs, 1'b0);
        check("midrst_we", mem_we, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_len", out_len, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("postrst_busy", busy, 1'b0);
        check("postrst_no_done", done_cnt, 0);

        random_pixels(25);
        run_frame(25, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
